minority_tally: RTL and testbench

- Parametrised, windowed successor to the 5-input minority gate.
- Accepts an N_IN-bit vote vector per handshake and accumulates the number of ones over WINDOW accepted samples.
- At window end, presents a registered verdict (minority, majority, threshold or tie) on a valid/ready output.
- Sits between sensor/replica channels and downstream voting/fault logic.

---
 rtl/tally_pkg.sv | 13 +
 rtl/popcount.sv | 13 +
 rtl/minority_tally.sv | 89 ++++++++
 tb/tb_minority_tally.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tally_pkg.sv
// tally_pkg: mode/state types and the window verdict function shared by minority_tally.
package tally_pkg;
  typedef enum logic [1:0] {MINORITY, MAJORITY, THRESHOLD, TIE} tally_mode_t;
  typedef enum logic {ACCUM, DONE} tally_state_t;
  function automatic logic verdict(input logic [31:0] sum, input logic [31:0] total,
                                   input tally_mode_t mode, input logic [31:0] thr);
    logic [31:0] s2;
    s2 = {sum[30:0], 1'b0};
    return (mode == MINORITY) ? (s2 < total) :
           (mode == MAJORITY) ? (s2 > total) :
           (mode == THRESHOLD) ? (sum >= thr) : (s2 == total);
  endfunction
endpackage

// File: rtl/popcount.sv
// popcount: combinational count of ones in an N_IN-bit vector.
module popcount #(
  parameter int N_IN = 5,
  parameter int CW = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0] i_bits,
  output logic [CW-1:0]   o_count
);
  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_IN; i++) o_count = o_count + CW'(i_bits[i]);
  end
endmodule

// File: rtl/minority_tally.sv
// minority_tally: windowed vote tally with registered verdict on a valid/ready output.
// Optional unanimous output enabled by MINORITY_TALLY_UNANIMOUS_EN.
module minority_tally import tally_pkg::*; #(
  parameter int N_IN = 5,
  parameter int WINDOW = 4,
  parameter int SUM_W = $clog2(N_IN * WINDOW + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  votes,
  input  logic [1:0]       mode,
  input  logic [SUM_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [SUM_W-1:0] count
`ifdef MINORITY_TALLY_UNANIMOUS_EN
  , output logic           unanimous
`endif
);
  localparam int PC_W = $clog2(N_IN + 1);
  localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int TOTAL = N_IN * WINDOW;
  tally_state_t     r_state;
  tally_mode_t      r_mode;
  logic [SUM_W-1:0] r_sum, r_thr, r_count;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid, r_result;
  logic [PC_W-1:0]  w_pc;
  logic [SUM_W-1:0] w_sum_n, w_thr;
  tally_mode_t      w_mode;
  logic             w_verdict, w_last;
  popcount #(.N_IN(N_IN)) u_pc (.i_bits(votes), .o_count(w_pc));
  // mode and threshold come from the port only on the first sample of a window
  assign w_mode    = (r_idx == '0) ? tally_mode_t'(mode) : r_mode;
  assign w_thr     = (r_idx == '0) ? threshold : r_thr;
  assign w_sum_n   = r_sum + SUM_W'(w_pc);
  assign w_last    = (r_idx == IDX_W'(WINDOW - 1));
  assign w_verdict = verdict(32'(w_sum_n), 32'(TOTAL), w_mode, 32'(w_thr));
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign count     = r_count;
`ifdef MINORITY_TALLY_UNANIMOUS_EN
  logic r_unan;
  assign unanimous = r_unan;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_unan <= 1'b0;
    else if (!clear && r_state == ACCUM && in_valid && w_last)
      r_unan <= (w_sum_n == '0) || (w_sum_n == SUM_W'(TOTAL));
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ACCUM;
      r_mode      <= MINORITY;
      r_sum       <= '0;
      r_thr       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      r_count     <= '0;
    end else if (clear) begin
      r_state     <= ACCUM;
      r_sum       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (in_valid) begin
        r_sum  <= w_sum_n;
        r_mode <= w_mode;
        r_thr  <= w_thr;
        r_idx  <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_count     <= w_sum_n;
          r_result    <= w_verdict;
        end
      end
    end else if (out_ready) begin
      r_state     <= ACCUM;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_minority_tally.sv
// tb_minority_tally: scoreboard bench for minority_tally (WINDOW=4 main DUT, WINDOW=1 gate DUT).
module tb_minority_tally;
  localparam int N = 5, W = 4, SW = $clog2(N * W + 1), GW = $clog2(N + 1), TOT = N * W;
  localparam logic [1:0] M_MIN = 2'd0, M_MAJ = 2'd1, M_THR = 2'd2, M_TIE = 2'd3;
  typedef struct {logic res; logic [SW-1:0] cnt; logic una;} exp_t;
  logic clock = 0, reset = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [N-1:0] votes = '0;
  logic [1:0] mode = '0;
  logic [SW-1:0] threshold = '0;
  logic in_ready, out_valid, result, unanimous;
  logic [SW-1:0] count;
  logic g_in_valid = 0, g_out_ready = 1, g_in_ready, g_out_valid, g_result, g_unan;
  logic [N-1:0] g_votes = '0;
  logic [1:0] g_mode = M_MIN;
  logic [GW-1:0] g_thr = '0, g_count;
  exp_t q[$], gq[$];
  int n_checks = 0, n_pass = 0;

  minority_tally #(.N_IN(N), .WINDOW(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .votes(votes), .mode(mode), .threshold(threshold), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .count(count)
`ifdef MINORITY_TALLY_UNANIMOUS_EN
    , .unanimous(unanimous)
`endif
  );
  minority_tally #(.N_IN(N), .WINDOW(1)) gdut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .votes(g_votes), .mode(g_mode), .threshold(g_thr), .out_valid(g_out_valid),
    .out_ready(g_out_ready), .result(g_result), .count(g_count)
`ifdef MINORITY_TALLY_UNANIMOUS_EN
    , .unanimous(g_unan)
`endif
  );
`ifndef MINORITY_TALLY_UNANIMOUS_EN
  assign unanimous = 1'b0;
  assign g_unan = 1'b0;
`endif

  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pop5(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic exp_t model(input int sum, input int total, input logic [1:0] m, input int thr);
    exp_t e;
    e.cnt = SW'(sum);
    e.res = (m == M_MIN) ? (2 * sum < total) : (m == M_MAJ) ? (2 * sum > total) :
            (m == M_THR) ? (sum >= thr) : (2 * sum == total);
    e.una = (sum == 0) || (sum == total);
    return e;
  endfunction

  task automatic send(input logic [N-1:0] v, input logic [1:0] m, input int thr);
    int n = 0;
    in_valid = 1; votes = v; mode = m; threshold = SW'(thr);
    while (!in_ready && n < 20) begin @(negedge clock); n++; end
    if (n == 20) begin n_checks++; $display("FAIL send_timeout in_ready=0 required 1"); end
    @(negedge clock);
    in_valid = 0;
  endtask

  task automatic window(input logic [N-1:0] v0, v1, v2, v3, input logic [1:0] mf, mr,
                        input int tf, tr);
    logic [N-1:0] v[4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    q.push_back(model(pop5(v0) + pop5(v1) + pop5(v2) + pop5(v3), TOT, mf, tf));
    for (int i = 0; i < 4; i++) send(v[i], (i == 0) ? mf : mr, (i == 0) ? tf : tr);
  endtask

  task automatic collect(input string name);
    exp_t e;
    int n = 0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL %s_latency out_valid got %b exp 1", name, out_valid);
    else n_pass++;
    while (!out_valid && n < 10) begin @(negedge clock); n++; end
    if (q.size() == 0) begin
      n_checks++; $display("FAIL %s scoreboard empty", name);
    end else begin
      e = q.pop_front();
      n_checks++;
      if (result !== e.res) $display("FAIL %s result got %b exp %b", name, result, e.res);
      else n_pass++;
      n_checks++;
      if (count !== e.cnt) $display("FAIL %s count got %0d exp %0d", name, count, e.cnt);
      else n_pass++;
`ifdef MINORITY_TALLY_UNANIMOUS_EN
      n_checks++;
      if (unanimous !== e.una) $display("FAIL %s unanimous got %b exp %b", name, unanimous, e.una);
      else n_pass++;
`endif
    end
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if (out_valid !== 0 || result !== 0 || count !== '0)
      $display("FAIL reset_outputs got v=%b r=%b c=%0d exp 0/0/0", out_valid, result, count);
    else n_pass++;
    reset = 0;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 1 || g_in_ready !== 1)
      $display("FAIL reset_in_ready got %b/%b exp 1/1", in_ready, g_in_ready);
    else n_pass++;
  endtask

  task automatic test_gate();
    exp_t e;
    for (int v = 0; v < 32; v++) begin
      g_in_valid = 1; g_votes = N'(v);
      gq.push_back(model(pop5(N'(v)), N, M_MIN, 0));
      @(negedge clock);
      g_in_valid = 0;
      n_checks++;
      if (g_out_valid !== 1) $display("FAIL gate_latency v=%0d out_valid got %b exp 1", v, g_out_valid);
      else n_pass++;
      e = gq.pop_front();
      n_checks++;
      if (g_result !== e.res) $display("FAIL gate_result v=%0d got %b exp %b", v, g_result, e.res);
      else n_pass++;
      n_checks++;
      if ({2'b00, g_count} !== e.cnt) $display("FAIL gate_count v=%0d got %0d exp %0d", v, g_count, e.cnt);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (g_out_valid !== 0 || g_in_ready !== 1)
        $display("FAIL gate_release v=%0d got %b/%b exp 0/1", v, g_out_valid, g_in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_minority_window();
    window(5'b00011, 5'b00011, 5'b00011, 5'b00011, M_MIN, M_MIN, 0, 0);
    collect("minority");
    window(5'b00011, 5'b00011, 5'b00011, 5'b00011, M_MAJ, M_MAJ, 0, 0);
    collect("minority_as_majority");
  endtask

  task automatic test_majority_threshold();
    window(5'b11111, 5'b11111, 5'b00000, 5'b00001, M_MAJ, M_MAJ, 0, 0);
    collect("majority");
    window(5'b11111, 5'b11111, 5'b00000, 5'b00001, M_THR, M_THR, 12, 12);
    collect("thr12");
    window(5'b11111, 5'b11111, 5'b00000, 5'b00001, M_THR, M_THR, 11, 11);
    collect("thr11");
    window(5'b11111, 5'b11111, 5'b00000, 5'b00001, M_THR, M_MIN, 11, 20);
    collect("captured_mode");
  endtask

  task automatic test_tie_backpressure();
    exp_t e;
    window(5'b00011, 5'b00111, 5'b00111, 5'b00011, M_TIE, M_TIE, 0, 0);
    e = q[0];
    in_valid = 1; votes = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1 || in_ready !== 0 || result !== e.res || count !== e.cnt)
        $display("FAIL hold%0d got v=%b rdy=%b r=%b c=%0d exp 1/0/%b/%0d",
                 i, out_valid, in_ready, result, count, e.res, e.cnt);
      else n_pass++;
    end
    in_valid = 0;
    collect("tie");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) send(5'b11111, M_MIN, 0);
    clear = 1; in_valid = 1; votes = 5'b11111;
    @(negedge clock);
    clear = 0; in_valid = 0;
    n_checks++;
    if (out_valid !== 0 || in_ready !== 1)
      $display("FAIL abort_drop got v=%b rdy=%b exp 0/1", out_valid, in_ready);
    else n_pass++;
    window(5'b00000, 5'b00000, 5'b00000, 5'b00000, M_MIN, M_MIN, 0, 0);
    collect("after_abort");
    for (int i = 0; i < 4; i++) send(5'b11111, M_MIN, 0);
    n_checks++;
    if (out_valid !== 1 || count !== SW'(TOT))
      $display("FAIL done_before_clear got v=%b c=%0d exp 1/%0d", out_valid, count, TOT);
    else n_pass++;
    clear = 1;
    @(negedge clock);
    clear = 0;
    n_checks++;
    if (out_valid !== 0 || in_ready !== 1)
      $display("FAIL clear_in_done got v=%b rdy=%b exp 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    send(5'b11111, M_MIN, 0);
    send(5'b11111, M_MIN, 0);
    #2 reset = 1;
    #1;
    n_checks++;
    if (out_valid !== 0 || count !== '0)
      $display("FAIL async_reset got v=%b c=%0d exp 0/0", out_valid, count);
    else n_pass++;
    #1 reset = 0;
    @(negedge clock);
    window(5'b00001, 5'b00001, 5'b00001, 5'b00001, M_MIN, M_MIN, 0, 0);
    collect("after_reset");
  endtask

  initial begin
    test_reset();
    test_gate();
    test_minority_window();
    test_majority_threshold();
    test_tie_backpressure();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
